// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the branch predictor and the pipeline.
//   CPU_ADDR_W      : default PC width
//   cnt_op_t        : operation selector for saturating counters
//   ctr_reset_val() : weakly-not-taken counter value (MSB=0, rest 1)
//   ctr_alloc_val() : weakly-taken counter value (MSB=1, rest 0)
//   bp_update_t     : branch resolution bundle carried by the ID/EX register
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 32;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_LOAD
    } cnt_op_t;

    // Returned 32 bits wide; callers truncate to their own counter width.
    function automatic logic [31:0] ctr_reset_val(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_alloc_val(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    typedef struct packed {
        logic                  en;
        logic [CPU_ADDR_W-1:0] pc;
        logic                  taken;
        logic [CPU_ADDR_W-1:0] target;
        logic                  pred_taken;
        logic [CPU_ADDR_W-1:0] pred_target;
    } bp_update_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with parallel load.
//   clk, reset : clock, synchronous active-high reset to RST_VAL
//   op         : hold / increment / decrement / load
//   load_val   : value taken on CNT_LOAD
//   q          : current count; never wraps past '1 or below '0
module sat_counter
    import cpu_pkg::*;
#(
    parameter int unsigned  W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  cnt_op_t      op,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else begin
            unique case (op)
                CNT_INC:  if (q != '1) q <= q + W'(1);
                CNT_DEC:  if (q != '0) q <= q - W'(1);
                CNT_LOAD: q <= load_val;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, mispredict detection and saturating performance counters.
//   if_pc / pred_taken / pred_target : zero-latency lookup for fetch
//   upd_*                            : resolved branch from EX, applied at edge
//   upd_mispredict                   : combinational redirect request
//   inv_all                          : clear every valid bit next edge
//   perf_updates / perf_mispredicts  : saturating event counters
module btb_predictor
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              upd_mispredict,
    input  logic              inv_all,
    output logic [PERF_W-1:0] perf_updates,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CTR_RST   = CNT_W'(ctr_reset_val(CNT_W));
    localparam logic [CNT_W-1:0] CTR_ALLOC = CNT_W'(ctr_alloc_val(CNT_W));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-3:0]  target_q [ENTRIES];
    logic [CNT_W-1:0]   ctr_q    [ENTRIES];
    cnt_op_t            ctr_op   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             if_hit;
    logic             upd_hit;
    logic             upd_apply;
    logic             alloc;
    logic             write_target;
    logic             unused_upd_pc_lsbs;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

    // Lookup reads registered state only, so a same-cycle update is not seen.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][CNT_W-1];
    assign pred_target = pred_taken ? {target_q[if_idx], 2'b00}
                                    : if_pc + ADDR_W'(4);

    assign upd_mispredict = upd_en &&
        ((upd_taken != upd_pred_taken) ||
         (upd_taken && (upd_target != upd_pred_target)));

    // inv_all drops the entry update but not the perf accounting.
    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_apply    = upd_en && !inv_all;
    assign alloc        = upd_apply && !upd_hit && upd_taken;
    assign write_target = upd_apply && upd_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Tags and targets carry no reset: a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_q[upd_idx] <= upd_tag;
        end
        if (write_target) begin
            target_q[upd_idx] <= upd_target[ADDR_W-1:2];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr_op[i] = CNT_HOLD;
            if (upd_apply && (upd_idx == IDX_W'(i))) begin
                if (upd_hit) begin
                    ctr_op[i] = upd_taken ? CNT_INC : CNT_DEC;
                end else if (upd_taken) begin
                    ctr_op[i] = CNT_LOAD;
                end
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        sat_counter #(
            .W       (CNT_W),
            .RST_VAL (CTR_RST)
        ) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .op       (ctr_op[g]),
            .load_val (CTR_ALLOC),
            .q        (ctr_q[g])
        );
    end

    cnt_op_t perf_upd_op;
    cnt_op_t perf_mis_op;

    assign perf_upd_op = upd_en         ? CNT_INC : CNT_HOLD;
    assign perf_mis_op = upd_mispredict ? CNT_INC : CNT_HOLD;

    sat_counter #(
        .W       (PERF_W),
        .RST_VAL ('0)
    ) u_perf_updates (
        .clk      (clk),
        .reset    (reset),
        .op       (perf_upd_op),
        .load_val ('0),
        .q        (perf_updates)
    );

    sat_counter #(
        .W       (PERF_W),
        .RST_VAL ('0)
    ) u_perf_mispredicts (
        .clk      (clk),
        .reset    (reset),
        .op       (perf_mis_op),
        .load_val ('0),
        .q        (perf_mispredicts)
    );

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios followed by
// randomized traffic, compared against an array-based reference model via
// a scoreboard queue drained by an independent monitor.
module tb_btb_predictor;

    localparam int unsigned AW  = 32;
    localparam int unsigned ENT = 16;
    localparam int unsigned CW  = 2;
    localparam int unsigned PW  = 8;

    localparam int          CTR_MAX       = (1 << CW) - 1;
    localparam int          CTR_TAKEN_MIN = 1 << (CW - 1);
    localparam int unsigned PERF_MAX      = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] if_pc;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_en;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;
    logic          upd_mispredict;
    logic          inv_all;
    logic [PW-1:0] perf_updates;
    logic [PW-1:0] perf_mispredicts;

    btb_predictor #(
        .ADDR_W  (AW),
        .ENTRIES (ENT),
        .CNT_W   (CW),
        .PERF_W  (PW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_en           (upd_en),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .upd_mispredict   (upd_mispredict),
        .inv_all          (inv_all),
        .perf_updates     (perf_updates),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            state_known;
        logic          exp_pt;
        logic [31:0]   exp_tgt;
        logic          exp_mp;
        logic [PW-1:0] exp_pu;
        logic [PW-1:0] exp_pm;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: plain arrays and integer arithmetic.
    bit          m_known = 1'b0;
    bit          m_valid  [ENT];
    int unsigned m_tag    [ENT];
    logic [31:0] m_target [ENT];
    int          m_ctr    [ENT];
    int unsigned m_pu = 0;
    int unsigned m_pm = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENT;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENT);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int unsigned i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == tag_of(pc));
    endfunction

    task automatic model_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
        pt  = model_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_TAKEN_MIN);
        tgt = pt ? m_target[idx_of(pc)] : pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit rst, input bit inv, input bit ue,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                        input bit upt, input logic [31:0] uptgt, input logic [31:0] ipc);
        exp_t        e;
        bit          mp;
        int unsigned i;
        reset           = rst;
        inv_all         = inv;
        upd_en          = ue;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        if_pc           = ipc;

        mp = ue && ((ut != upt) || (ut && (utgt != uptgt)));
        e.state_known = m_known;
        model_lookup(ipc, e.exp_pt, e.exp_tgt);
        e.exp_mp = mp;
        e.exp_pu = PW'(m_pu);
        e.exp_pm = PW'(m_pm);
        sb.push_back(e);

        if (rst) begin
            for (int k = 0; k < ENT; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = CTR_TAKEN_MIN - 1;
            end
            m_pu    = 0;
            m_pm    = 0;
            m_known = 1'b1;
        end else begin
            if (ue && m_pu < PERF_MAX) m_pu++;
            if (mp && m_pm < PERF_MAX) m_pm++;
            if (inv) begin
                for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
            end else if (ue) begin
                i = idx_of(upc);
                if (model_hit(upc)) begin
                    if (ut) begin
                        if (m_ctr[i] < CTR_MAX) m_ctr[i]++;
                        m_target[i] = utgt & 32'hFFFF_FFFC;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i]--;
                    end
                end else if (ut) begin
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = tag_of(upc);
                    m_target[i] = utgt & 32'hFFFF_FFFC;
                    m_ctr[i]    = CTR_TAKEN_MIN;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] ipc);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, ipc);
    endtask

    task automatic upd(input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit upt, input logic [31:0] uptgt, input logic [31:0] ipc);
        step(1'b0, 1'b0, 1'b1, upc, ut, utgt, upt, uptgt, ipc);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("upd_mispredict", 32'(upd_mispredict), 32'(e.exp_mp));
                if (e.state_known) begin
                    check("pred_taken", 32'(pred_taken), 32'(e.exp_pt));
                    check("pred_target", pred_target, e.exp_tgt);
                    check("perf_updates", 32'(perf_updates), 32'(e.exp_pu));
                    check("perf_mispredicts", 32'(perf_mispredicts), 32'(e.exp_pm));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; inv_all = 1'b0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; if_pc = '0;
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40);
        look(32'h40);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 32'h40);
        look(32'h40);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 32'h40);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 32'h40);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 32'h40);
        look(32'h40);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 32'h40);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 32'h40);
        look(32'h40);
        upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 32'h40);
        look(32'h40);
        look(32'h80);
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h200, 32'h80);
        look(32'h80);
        look(32'hFFFF_FFFC);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            pc = rand_pc();
            upd(pc, 1'b0, 32'h0, 1'b0, pc + 32'd4, rand_pc());
        end

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] upc, ipc, utgt, ptgt;
            logic        ppt;
            bit          ut, ue, inv, rst;
            upc  = rand_pc();
            ipc  = ($urandom_range(0, 3) == 0) ? upc : rand_pc();
            ut   = 1'($urandom_range(0, 1));
            utgt = ($urandom_range(0, 7) == 0) ? $urandom : rand_pc();
            model_lookup(upc, ppt, ptgt);
            if ($urandom_range(0, 7) == 0) ppt = ~ppt;
            if ($urandom_range(0, 15) == 0) ptgt = rand_pc();
            ue  = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step(rst, inv, ue, upc, ut, utgt, ppt, ptgt, ipc);
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
